// File: rtl/ristretto_prefetch_queue.sv
// Instruction prefetch queue for the ristretto IF stage: issues pipelined fetches,
// buffers returned words with PC/error, and drops in-flight wrong-path responses on flush.
module ristretto_prefetch_queue #(
  parameter int unsigned          DataWidth      = 32,
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          Depth          = 8,
  parameter int unsigned          MaxOutstanding = 2,
  parameter bit                   Bypass         = 1'b1,
  parameter logic [AddrWidth-1:0] BootAddr       = 'h80
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  input  logic [AddrWidth-1:0]       flush_pc_i,
  output logic                       fu_req_o,
  output logic [AddrWidth-1:0]       fu_addr_o,
  input  logic                       fu_gnt_i,
  input  logic                       fu_rvalid_i,
  input  logic [DataWidth-1:0]       fu_rdata_i,
  input  logic                       fu_err_i,
  output logic                       if_valid_o,
  input  logic                       if_ready_i,
  output logic [DataWidth-1:0]       if_instr_o,
  output logic [AddrWidth-1:0]       if_pc_o,
  output logic                       if_err_o,
  output logic [$clog2(Depth+1)-1:0] pb_count_o,
  output logic                       pb_active_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned FillW = CntW + 1;

  typedef struct packed {
    logic [DataWidth-1:0] instr;
    logic [AddrWidth-1:0] pc;
    logic                 err;
  } entry_t;

  entry_t               mem_q [Depth];
  logic [PtrW-1:0]      head_q, tail_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [OutW-1:0]      outstanding_q, outstanding_d;
  logic [OutW-1:0]      discard_q, discard_d;
  logic [OutW-1:0]      live;
  logic [FillW-1:0]     fill;
  logic [AddrWidth-1:0] req_pc_q, rsp_pc_q;
  logic                 run_q, active_q;
  logic                 queue_empty, grant, rsp_live, bypass_hit, push, pop;
  entry_t               rsp_entry, if_entry;

  // Credits: live responses plus stored entries never exceed Depth.
  assign live        = outstanding_q - discard_q;
  assign fill        = FillW'(live) + FillW'(count_q);
  assign queue_empty = (count_q == '0);

  // run_q holds requests off while in reset and for the first edge after release.
  assign fu_req_o  = run_q & ~flush_i & (outstanding_q < OutW'(MaxOutstanding))
                   & (fill < FillW'(Depth));
  assign fu_addr_o = req_pc_q;
  assign grant     = fu_req_o & fu_gnt_i;

  assign rsp_live   = fu_rvalid_i & ~flush_i & (discard_q == '0);
  assign rsp_entry  = '{instr: fu_rdata_i, pc: rsp_pc_q, err: fu_err_i};
  assign bypass_hit = Bypass & queue_empty & rsp_live;

  assign if_valid_o = ~flush_i & (~queue_empty | bypass_hit);
  assign if_entry   = bypass_hit ? rsp_entry : mem_q[tail_q];
  assign if_instr_o = if_entry.instr;
  assign if_pc_o    = if_entry.pc;
  assign if_err_o   = if_entry.err;

  assign pop  = if_valid_o & if_ready_i & ~queue_empty;
  assign push = rsp_live & ~(bypass_hit & if_ready_i);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (flush_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      count_d       = '0;
      outstanding_d = outstanding_q - OutW'(fu_rvalid_i);
      discard_d     = outstanding_q - OutW'(fu_rvalid_i);
    end else begin
      count_d       = count_q + CntW'(push) - CntW'(pop);
      outstanding_d = outstanding_q + OutW'(grant) - OutW'(fu_rvalid_i);
      discard_d     = discard_q - OutW'(fu_rvalid_i & (discard_q != '0));
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      req_pc_q      <= BootAddr;
      rsp_pc_q      <= BootAddr;
      run_q         <= 1'b0;
      active_q      <= 1'b0;
      // NOTE: the entry array is reset too, so if_* data reads zero after reset.
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      run_q         <= 1'b1;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      active_q      <= (count_d != '0);
      if (flush_i) begin
        head_q   <= '0;
        tail_q   <= '0;
        req_pc_q <= flush_pc_i;
        rsp_pc_q <= flush_pc_i;
      end else begin
        if (grant)    req_pc_q <= req_pc_q + AddrWidth'(4);
        if (rsp_live) rsp_pc_q <= rsp_pc_q + AddrWidth'(4);
        if (push) begin
          mem_q[head_q] <= rsp_entry;
          head_q        <= head_q + 1'b1;
        end
        if (pop) tail_q <= tail_q + 1'b1;
      end
    end
  end

  assign pb_count_o  = count_q;
  assign pb_active_o = active_q;

  assert property (@(posedge clk_i) disable iff (!rstn_i)
    fu_rvalid_i |-> (outstanding_q != '0));
  assert property (@(posedge clk_i) disable iff (!rstn_i)
    rsp_live |-> (fill <= FillW'(Depth)));

endmodule

// File: tb/tb_ristretto_prefetch_queue.sv
// Directed bench for ristretto_prefetch_queue: streaming bypass, fill/drain,
// flush discard, error tagging and asynchronous reset mid-stream.
module tb_ristretto_prefetch_queue;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        fu_req_o;
  logic [31:0] fu_addr_o;
  logic        fu_gnt_i = 1'b0;
  logic        fu_rvalid_i = 1'b0;
  logic [31:0] fu_rdata_i = '0;
  logic        fu_err_i = 1'b0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b0;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        if_err_o;
  logic [3:0]  pb_count_o;
  logic        pb_active_o;

  int n_checks = 0;
  int n_fail   = 0;

  ristretto_prefetch_queue #(
    .DataWidth(32), .AddrWidth(32), .Depth(8), .MaxOutstanding(2),
    .Bypass(1'b1), .BootAddr(32'h0000_0080)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fu_req_o(fu_req_o), .fu_addr_o(fu_addr_o), .fu_gnt_i(fu_gnt_i),
    .fu_rvalid_i(fu_rvalid_i), .fu_rdata_i(fu_rdata_i), .fu_err_i(fu_err_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_instr_o(if_instr_o),
    .if_pc_o(if_pc_o), .if_err_o(if_err_o), .pb_count_o(pb_count_o),
    .pb_active_o(pb_active_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(if_valid_o), 64'd1);
    check({tag, ".pc"},    64'(if_pc_o),    64'(pc));
    check({tag, ".instr"}, 64'(if_instr_o), 64'(instr_of(pc)));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic gnt, input logic rv, input logic [31:0] rpc,
                       input logic err, input logic rdy, input logic fl,
                       input logic [31:0] fpc);
    fu_gnt_i    = gnt;
    fu_rvalid_i = rv;
    fu_rdata_i  = rv ? instr_of(rpc) : '0;
    fu_err_i    = err;
    if_ready_i  = rdy;
    flush_i     = fl;
    flush_pc_i  = fpc;
    #1;
  endtask

  task automatic do_reset(input string tag);
    rstn_i      = 1'b0;
    fu_gnt_i    = 1'b0;
    fu_rvalid_i = 1'b0;
    fu_rdata_i  = '0;
    fu_err_i    = 1'b0;
    if_ready_i  = 1'b0;
    flush_i     = 1'b0;
    flush_pc_i  = '0;
    #1;
    check({tag, ".fu_req"},    64'(fu_req_o),    64'd0);
    check({tag, ".fu_addr"},   64'(fu_addr_o),   64'h80);
    check({tag, ".if_valid"},  64'(if_valid_o),  64'd0);
    check({tag, ".pb_count"},  64'(pb_count_o),  64'd0);
    check({tag, ".pb_active"}, 64'(pb_active_o), 64'd0);
    check({tag, ".if_instr"},  64'(if_instr_o),  64'd0);
    check({tag, ".if_pc"},     64'(if_pc_o),     64'd0);
    check({tag, ".if_err"},    64'(if_err_o),    64'd0);
    tick();
    tick();
    rstn_i = 1'b1;
    tick();
  endtask

  initial begin
    #1;
    do_reset("rst0");

    // Streaming with 1-cycle responses and a ready consumer: zero queue latency.
    drive(1, 0, 0, 0, 1, 0, 0);
    check("s0.fu_req", 64'(fu_req_o), 64'd1);
    check("s0.fu_addr", 64'(fu_addr_o), 64'h80);
    check("s0.if_valid", 64'(if_valid_o), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h80 + 32'(4 * i), 0, 1, 0, 0);
      check("s.fu_addr", 64'(fu_addr_o), 64'(32'h84 + 32'(4 * i)));
      chk_if("s.if", 32'h80 + 32'(4 * i));
      check("s.pb_count", 64'(pb_count_o), 64'd0);
      tick();
    end
    check("s.pb_active", 64'(pb_active_o), 64'd0);
    do_reset("rst1");

    // Fill with the consumer stalled: exactly Depth responses accepted.
    drive(1, 0, 0, 0, 0, 0, 0);
    check("f0.fu_addr", 64'(fu_addr_o), 64'h80);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 32'h80 + 32'(4 * i), 0, 0, 0, 0);
      check("f.fu_req", 64'(fu_req_o), 64'(i < 7));
      check("f.fu_addr", 64'(fu_addr_o), 64'(32'h84 + 32'(4 * i)));
      check("f.pb_count", 64'(pb_count_o), 64'(i));
      chk_if("f.if", 32'h80);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    check("full.fu_req", 64'(fu_req_o), 64'd0);
    check("full.pb_count", 64'(pb_count_o), 64'd8);
    check("full.pb_active", 64'(pb_active_o), 64'd1);
    tick();

    // Drain in order; requests resume once a slot frees.
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      chk_if("d.if", 32'h80 + 32'(4 * i));
      check("d.pb_count", 64'(pb_count_o), 64'(8 - i));
      check("d.fu_req", 64'(fu_req_o), 64'(i >= 1));
      tick();
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    check("empty.if_valid", 64'(if_valid_o), 64'd0);
    check("empty.pb_count", 64'(pb_count_o), 64'd0);
    check("empty.pb_active", 64'(pb_active_o), 64'd0);
    check("empty.fu_addr", 64'(fu_addr_o), 64'hA0);
    tick();

    // Flush with two outstanding (back-to-back flushes, last target wins).
    drive(1, 0, 0, 0, 1, 0, 0);
    check("e0.fu_addr", 64'(fu_addr_o), 64'hA0);
    tick();
    drive(1, 0, 0, 0, 1, 0, 0);
    check("e1.fu_req", 64'(fu_req_o), 64'd1);
    check("e1.fu_addr", 64'(fu_addr_o), 64'hA4);
    tick();
    drive(1, 0, 0, 0, 1, 1, 32'h300);
    check("e2.fu_req", 64'(fu_req_o), 64'd0);
    check("e2.if_valid", 64'(if_valid_o), 64'd0);
    tick();
    drive(1, 0, 0, 0, 1, 1, 32'h400);
    check("e2b.fu_req", 64'(fu_req_o), 64'd0);
    check("e2b.fu_addr", 64'(fu_addr_o), 64'h300);
    tick();
    drive(0, 1, 32'hA0, 0, 1, 0, 0);
    check("e3.if_valid", 64'(if_valid_o), 64'd0);
    check("e3.fu_req", 64'(fu_req_o), 64'd0);
    tick();
    drive(0, 1, 32'hA4, 0, 1, 0, 0);
    check("e4.if_valid", 64'(if_valid_o), 64'd0);
    check("e4.fu_req", 64'(fu_req_o), 64'd1);
    check("e4.fu_addr", 64'(fu_addr_o), 64'h400);
    tick();
    drive(1, 0, 0, 0, 1, 0, 0);
    check("e5.fu_addr", 64'(fu_addr_o), 64'h400);
    tick();
    drive(0, 1, 32'h400, 0, 1, 0, 0);
    chk_if("e6.if", 32'h400);
    tick();

    // Flush coincident with a response, one other outstanding.
    drive(1, 0, 0, 0, 1, 0, 0);
    check("g0.fu_addr", 64'(fu_addr_o), 64'h404);
    tick();
    drive(1, 0, 0, 0, 1, 0, 0);
    check("g1.fu_addr", 64'(fu_addr_o), 64'h408);
    tick();
    drive(1, 1, 32'h404, 0, 1, 1, 32'h400);
    check("g2.if_valid", 64'(if_valid_o), 64'd0);
    check("g2.fu_req", 64'(fu_req_o), 64'd0);
    tick();
    drive(0, 1, 32'h408, 0, 1, 0, 0);
    check("g3.if_valid", 64'(if_valid_o), 64'd0);
    check("g3.fu_req", 64'(fu_req_o), 64'd1);
    check("g3.fu_addr", 64'(fu_addr_o), 64'h400);
    tick();
    drive(1, 0, 0, 0, 1, 0, 0);
    check("g4.fu_addr", 64'(fu_addr_o), 64'h400);
    tick();
    drive(0, 1, 32'h400, 0, 1, 0, 0);
    chk_if("g5.if", 32'h400);
    tick();
    do_reset("rst2");

    // Error bit travels with its own entry only.
    drive(1, 0, 0, 0, 0, 0, 0);
    check("r0.fu_addr", 64'(fu_addr_o), 64'h80);
    tick();
    drive(1, 1, 32'h80, 0, 0, 0, 0);
    chk_if("r1.if", 32'h80);
    check("r1.if_err", 64'(if_err_o), 64'd0);
    tick();
    drive(0, 1, 32'h84, 1, 0, 0, 0);
    chk_if("r2.if", 32'h80);
    check("r2.if_err", 64'(if_err_o), 64'd0);
    check("r2.pb_count", 64'(pb_count_o), 64'd1);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    chk_if("r3.if", 32'h80);
    check("r3.if_err", 64'(if_err_o), 64'd0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    chk_if("r4.if", 32'h84);
    check("r4.if_err", 64'(if_err_o), 64'd1);
    tick();
    drive(1, 0, 0, 0, 1, 0, 0);
    check("r5.fu_addr", 64'(fu_addr_o), 64'h88);
    tick();
    drive(0, 1, 32'h88, 0, 1, 0, 0);
    chk_if("r6.if", 32'h88);
    check("r6.if_err", 64'(if_err_o), 64'd0);
    tick();

    // Build 5 queued + 2 outstanding, then reset asynchronously.
    drive(1, 0, 0, 0, 0, 0, 0);
    check("h0.fu_addr", 64'(fu_addr_o), 64'h8C);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'h8C + 32'(4 * i), 0, 0, 0, 0);
      check("h.fu_req", 64'(fu_req_o), 64'd1);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    check("h6.fu_addr", 64'(fu_addr_o), 64'hA4);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("h7.pb_count", 64'(pb_count_o), 64'd5);
    check("h7.fu_req", 64'(fu_req_o), 64'd0);
    check("h7.pb_active", 64'(pb_active_o), 64'd1);
    chk_if("h7.if", 32'h8C);
    do_reset("rst3");
    drive(1, 0, 0, 0, 1, 0, 0);
    check("x0.fu_req", 64'(fu_req_o), 64'd1);
    check("x0.fu_addr", 64'(fu_addr_o), 64'h80);
    tick();
    drive(0, 1, 32'h80, 0, 1, 0, 0);
    chk_if("x1.if", 32'h80);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
